// File: rtl/requant_out_packer_if.sv
// Element stream in, 32-bit output-buffer write port out; the packer uses slave, its environment uses master.
interface requant_out_packer_if #(
    parameter int BW_INDEX = 13
);
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic [BW_INDEX-1:0] obuff_index;
    logic                obuff_enable;
    logic [3:0]          obuff_wbe;
    logic [31:0]         obuff_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  obuff_index,
        input  obuff_enable,
        input  obuff_wbe,
        input  obuff_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output obuff_index,
        output obuff_enable,
        output obuff_wbe,
        output obuff_wdata
    );
endinterface

// File: rtl/requant_out_packer.sv
// Packs int8 elements little-endian into 32-bit buffer words; a word write issues one cycle after its filling element.
// One element per cycle while busy; in_ready is purely the PACK state, the buffer side never stalls.
module requant_out_packer #(
    parameter int BW_INDEX = 13,
    parameter int BW_COUNT = 32
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                start,
    input  logic [BW_INDEX-1:0] base_index,
    input  logic [BW_COUNT-1:0] total_count,
    requant_out_packer_if.slave bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BW_INDEX-1:0] word_idx_q, word_idx_d;
    logic [BW_COUNT-1:0] total_q,    total_d;
    logic [BW_COUNT-1:0] cnt_q,      cnt_d;
    logic [31:0]         word_q,     word_d;
    logic [3:0]          mask_q,     mask_d;

    logic                obuff_enable_q, obuff_enable_d;
    logic [BW_INDEX-1:0] obuff_index_q,  obuff_index_d;
    logic [3:0]          obuff_wbe_q,    obuff_wbe_d;
    logic [31:0]         obuff_wdata_q,  obuff_wdata_d;

    logic        in_ready;
    logic        accept;
    logic        last_elem;
    logic [1:0]  lane;
    logic [31:0] word_new;
    logic [3:0]  mask_new;

    assign accept    = bus.in_valid && in_ready;
    assign lane      = cnt_q[1:0];
    assign last_elem = (cnt_q == (total_q - BW_COUNT'(1)));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rstnn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (total_count == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (accept && last_elem) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_PACK:  begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Merge the incoming byte into its lane of the word being assembled.
    always_comb begin
        word_new               = word_q;
        word_new[8*lane +: 8]  = bus.in_data;
        mask_new               = mask_q | (4'b0001 << lane);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        word_idx_d     = word_idx_q;
        total_d        = total_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        mask_d         = mask_q;
        obuff_enable_d = 1'b0;
        obuff_index_d  = obuff_index_q;
        obuff_wbe_d    = 4'b0000;
        obuff_wdata_d  = 32'h0000_0000;

        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            word_idx_d = base_index;
            total_d    = total_count;
            cnt_d      = '0;
            word_d     = 32'h0000_0000;
            mask_d     = 4'b0000;
        end else if (accept) begin
            cnt_d = cnt_q + BW_COUNT'(1);
            // A word goes out when lane 3 fills or the job's last element lands.
            if (lane == 2'd3 || last_elem) begin
                obuff_enable_d = 1'b1;
                obuff_index_d  = word_idx_q;
                obuff_wbe_d    = mask_new;
                obuff_wdata_d  = word_new;
                word_d         = 32'h0000_0000;
                mask_d         = 4'b0000;
                word_idx_d     = word_idx_q + BW_INDEX'(1);
            end else begin
                word_d = word_new;
                mask_d = mask_new;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rstnn) begin
            word_idx_q     <= '0;
            total_q        <= '0;
            cnt_q          <= '0;
            word_q         <= 32'h0000_0000;
            mask_q         <= 4'b0000;
            obuff_enable_q <= 1'b0;
            obuff_index_q  <= '0;
            obuff_wbe_q    <= 4'b0000;
            obuff_wdata_q  <= 32'h0000_0000;
        end else begin
            word_idx_q     <= word_idx_d;
            total_q        <= total_d;
            cnt_q          <= cnt_d;
            word_q         <= word_d;
            mask_q         <= mask_d;
            obuff_enable_q <= obuff_enable_d;
            obuff_index_q  <= obuff_index_d;
            obuff_wbe_q    <= obuff_wbe_d;
            obuff_wdata_q  <= obuff_wdata_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.obuff_enable = obuff_enable_q;
    assign bus.obuff_index  = obuff_index_q;
    assign bus.obuff_wbe    = obuff_wbe_q;
    assign bus.obuff_wdata  = obuff_wdata_q;

endmodule

// File: doc/requant_out_packer.md
REQUANT_OUT_PACKER -- requirements
Module: requant_out_packer

Interface
REQ-001 The block SHALL have parameter BW_INDEX, default 13, giving the output buffer word-index width (8192 words of 32 bits).
REQ-002 The block SHALL have parameter BW_COUNT, default 32, giving the element-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rstnn, input, 1 bit: synchronous, active-high reset (1 = reset).
REQ-005 The block SHALL have port start, input, 1 bit: job-start pulse.
REQ-006 The block SHALL have port base_index, input, BW_INDEX bits: first output word index, sampled at start.
REQ-007 The block SHALL have port total_count, input, BW_COUNT bits: number of int8 elements in the job, sampled at start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a requantized element is present.
REQ-009 The block SHALL have port in_data, input, 8 bits: the requantized int8 element.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts an element.
REQ-011 The block SHALL have port obuff_index, output, BW_INDEX bits: output buffer write index.
REQ-012 The block SHALL have port obuff_enable, output, 1 bit: output buffer write strobe.
REQ-013 The block SHALL have port obuff_wbe, output, 4 bits: byte-write enables.
REQ-014 The block SHALL have port obuff_wdata, output, 32 bits: write data.
REQ-015 The block SHALL have port busy, output, 1 bit: a job is in progress.
REQ-016 The block SHALL have port done, output, 1 bit: the job is complete, held high.

Function
REQ-017 The block SHALL have states IDLE, PACK and DONE.
REQ-018 IDLE or DONE plus start: the block SHALL latch base_index and total_count, clear done, and go to PACK, or go to DONE next cycle if total_count == 0.
REQ-019 start SHALL be ignored while in PACK.
REQ-020 in_ready SHALL equal (state == PACK), combinationally; there is no backpressure from the buffer side.
REQ-021 An element SHALL be accepted only on a cycle with in_valid && in_ready.
REQ-022 Element k (0-based, in acceptance order) SHALL go to byte lane k mod 4 (bits 8*(k mod 4)+7 : 8*(k mod 4), little-endian) of word base_index + floor(k/4), with the index taken modulo 2^BW_INDEX.
REQ-023 Elements SHALL be accumulated in an internal 32-bit word register with a 4-bit lane mask.
REQ-024 When the accepted element fills lane 3 or is element total_count-1, the block SHALL pulse obuff_enable for exactly one cycle on the following cycle, with:
- obuff_index = the current word index;
- obuff_wdata = the accumulated word, with unfilled lanes 0;
- obuff_wbe = the lane mask.
REQ-025 After such a write, the word register and mask SHALL clear, and the word index SHALL increment, wrapping from 2^BW_INDEX-1 to 0.
REQ-026 When obuff_enable = 0, obuff_wbe and obuff_wdata SHALL be 0; obuff_index SHALL hold its last value.
REQ-027 On acceptance of the last element, the state SHALL go to DONE; the final write pulse SHALL coincide with the first DONE cycle.
REQ-028 busy SHALL be 1 exactly in PACK.
REQ-029 done SHALL be 1 exactly in DONE.
REQ-030 The element counter SHALL be BW_COUNT bits, and counting SHALL never exceed total_count.
REQ-031 Throughput SHALL be one element per cycle; gaps in in_valid SHALL only stall, with no effect on content.

Reset
REQ-032 While rstnn = 1 at a clock edge, the block SHALL go to IDLE and clear:
- in_ready, obuff_enable, obuff_wbe, obuff_wdata, obuff_index, busy and done to 0;
- the counters, word register and mask.
REQ-033 A reset mid-job SHALL abandon the job: no pending partial word is written, and the block SHALL wait for a new start.

Verification
REQ-034 Full words: base 0x010, count 8, bytes 0x01..0x08 back-to-back -> index 0x010 data 0x04030201 wbe 0xF, then index 0x011 data 0x08070605 wbe 0xF, done = 1 with the second write.
REQ-035 Partial last word: base 0x020, count 6, bytes 0x01..0x06 -> second write at index 0x021, data 0x00000605, wbe 0x3.
REQ-036 Empty job: count 0 -> no obuff_enable, busy never 1, done = 1 one cycle after start.
REQ-037 Gaps and wrap: base 0x1FFF, count 8, in_valid toggling 1/0 -> writes at 0x1FFF then 0x0000 with the same data as REQ-034.
REQ-038 Ignored start: start pulsed mid-job -> no change to index or count, job completes as in REQ-034.
REQ-039 Reset mid-job: reset after 3 of 8 elements -> no write, all outputs 0, IDLE; a new job then behaves as in REQ-034.
